// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//
// Handshaked, iterative AES column-mixing stage. A captured 128-bit state is
// run through forward MixColumns, InvMixColumns, or passed through unchanged
// (bypass). LANES columns are transformed per cycle, so one block takes
// NCYC = 4/LANES compute cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   din        input state, column j = din[32j +: 32], byte S0c is the column MSB
//   inv        1 = InvMixColumns, 0 = MixColumns (sampled with din)
//   bypass     1 = result equals the captured din (sampled with din)
//   in_valid   din/inv/bypass valid
//   in_ready   block can accept a new input (IDLE and not in reset)
//   dout       result, same column/byte ordering as din
//   out_valid  dout valid (DONE state)
//   out_ready  downstream accepts dout
//   busy       state != IDLE
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. A source holds valid and its data stable
// until that edge; ready may be deasserted at any time and valid without ready
// is simply ignored. dout/out_valid stay stable until out_ready is seen.
// -----------------------------------------------------------------------------
module mix_columns_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] din,
    input  logic         inv,
    input  logic         bypass,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int NCYC = 4 / LANES;

    // Only 1, 2 and 4 lanes divide the four columns evenly.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
            $error("mix_columns_seq: LANES must be 1, 2 or 4");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // GF(2^8) helpers
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Transforms one column. Each input byte a[i] is multiplied by the four
    // matrix coefficients it meets (k0..k3, by distance from the output row)
    // using one shared xtime chain a -> 2a -> 4a -> 8a:
    //   forward : k0 = 02, k1 = 03, k2 = 01, k3 = 01
    //   inverse : k0 = 0e, k1 = 0b, k2 = 0d, k3 = 09
    // Output row i = k0[i] ^ k1[i+1] ^ k2[i+2] ^ k3[i+3] (indices mod 4).
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv_mode);
        logic [7:0]  a  [4];
        logic [7:0]  x1 [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x3 [4];
        logic [7:0]  k0 [4];
        logic [7:0]  k1 [4];
        logic [7:0]  k2 [4];
        logic [7:0]  k3 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x1[i] = xtime(a[i]);
            x2[i] = xtime(x1[i]);
            x3[i] = xtime(x2[i]);
            if (inv_mode) begin
                k0[i] = x3[i] ^ x2[i] ^ x1[i];
                k1[i] = x3[i] ^ x1[i] ^ a[i];
                k2[i] = x3[i] ^ x2[i] ^ a[i];
                k3[i] = x3[i] ^ a[i];
            end else begin
                k0[i] = x1[i];
                k1[i] = x1[i] ^ a[i];
                k2[i] = a[i];
                k3[i] = a[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = k0[i] ^ k1[(i+1)%4] ^ k2[(i+2)%4] ^ k3[(i+3)%4];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   cnt;        // first column handled this cycle
    logic [0:127] work;       // captured state, transformed in place
    logic [0:127] work_next;
    logic [0:127] dout_q;
    logic         inv_q;
    logic         bypass_q;
    logic [1:0]   col_idx;

    logic         capture;    // input handshake this cycle
    logic         step;       // transform columns this cycle
    logic         last;       // this BUSY cycle completes the block

    // Final BUSY cycle: cnt + LANES reaches 4 (computed in 3 bits so that
    // LANES = 4 does not wrap).
    assign last = ({1'b0, cnt} + 3'(LANES)) == 3'd4;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        capture    = 1'b0;
        step       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign dout = dout_q;

    // -------------------------------------------------------------------------
    // Column transform for the lanes active this cycle. Bypass leaves the
    // captured state untouched so the result is the original din.
    // -------------------------------------------------------------------------
    always_comb begin
        work_next = work;
        col_idx   = '0;
        if (!bypass_q) begin
            for (int l = 0; l < LANES; l++) begin
                col_idx = cnt + 2'(l);
                work_next[{col_idx, 5'b0} +: 32] =
                    mix_col(work[{col_idx, 5'b0} +: 32], inv_q);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            work     <= '0;
            dout_q   <= '0;
            inv_q    <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            if (capture) begin
                work     <= din;
                inv_q    <= inv;
                bypass_q <= bypass;
                cnt      <= '0;
            end else if (step) begin
                work <= work_next;
                // Wraps to 0 after the last group of columns.
                cnt  <= cnt + 2'(LANES);
                if (last) begin
                    dout_q <= work_next;
                end
            end
        end
    end

    // NCYC documents the block latency; it is not needed by the logic itself.
    logic unused_ncyc;
    assign unused_ncyc = (NCYC == 0);

endmodule

// File: tb/tb_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_seq
//
// Directed bench for mix_columns_seq with three instances: index 0 uses
// LANES=1, index 1 LANES=2, index 2 LANES=4. Expected results are FIPS-197
// reference values written out by hand.
// -----------------------------------------------------------------------------
module tb_mix_columns_seq;

    // -------------------------------------------------------------------------
    // Clock and signals
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [3];
    logic [0:127] din       [3];
    logic         inv       [3];
    logic         bypass    [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [0:127] dout      [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy      [3];

    mix_columns_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .din(din[0]), .inv(inv[0]), .bypass(bypass[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .dout(dout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0])
    );

    mix_columns_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst[1]), .din(din[1]), .inv(inv[1]), .bypass(bypass[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .dout(dout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1])
    );

    mix_columns_seq #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .din(din[2]), .inv(inv[2]), .bypass(bypass[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .dout(dout[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2])
    );

    // Reference vectors
    localparam logic [127:0] V_SHIFTED = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_MIXED   = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] V_COL_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] V_COL_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

    int checks   = 0;
    int failures = 0;

    // -------------------------------------------------------------------------
    // Scoreboard helpers
    // -------------------------------------------------------------------------
    task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then performs one input handshake.
    task automatic start(input int k, input logic [127:0] d, input logic i,
                         input logic b, input string tag);
        int n;
        n = 0;
        while (!in_ready[k] && n < 20) begin
            tick();
            n++;
        end
        chk_bit({tag, " in_ready"}, in_ready[k], 1'b1);
        din[k]      = d;
        inv[k]      = i;
        bypass[k]   = b;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        chk_bit({tag, " busy"}, busy[k], 1'b1);
    endtask

    // Counts cycles from the handshake to out_valid and checks the result.
    task automatic wait_out(input int k, input int exp_lat, input logic [127:0] exp,
                            input string tag);
        int n;
        n = 0;
        while (!out_valid[k] && n < 20) begin
            tick();
            n++;
        end
        chk_int({tag, " latency"}, n, exp_lat);
        chk_vec({tag, " dout"}, dout[k], exp);
    endtask

    task automatic release_out(input int k, input string tag);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        chk_bit({tag, " in_ready after release"}, in_ready[k], 1'b1);
        chk_bit({tag, " out_valid after release"}, out_valid[k], 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    int           n;
    logic [127:0] held;
    int           seen_valid;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            din[k]       = '0;
            inv[k]       = 1'b0;
            bypass[k]    = 1'b0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_bit("reset in_ready", in_ready[k], 1'b0);
            chk_bit("reset out_valid", out_valid[k], 1'b0);
            chk_bit("reset busy", busy[k], 1'b0);
            chk_vec("reset dout", dout[k], 128'h0);
            rst[k] = 1'b0;
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_bit("post-reset in_ready", in_ready[k], 1'b1);
        end

        // Forward, LANES=4
        start(2, V_SHIFTED, 1'b0, 1'b0, "fwd_l4");
        wait_out(2, 1, V_MIXED, "fwd_l4");
        release_out(2, "fwd_l4");

        // Inverse round trip, LANES=1
        start(0, V_MIXED, 1'b1, 1'b0, "inv_l1");
        wait_out(0, 4, V_SHIFTED, "inv_l1");
        release_out(0, "inv_l1");

        // Column vectors, LANES=2: forward, bypass, inverse
        start(1, V_COL_IN, 1'b0, 1'b0, "fwd_l2");
        wait_out(1, 2, V_COL_OUT, "fwd_l2");
        release_out(1, "fwd_l2");

        start(1, V_COL_IN, 1'b0, 1'b1, "byp_l2");
        wait_out(1, 2, V_COL_IN, "byp_l2");
        release_out(1, "byp_l2");

        start(1, V_COL_OUT, 1'b1, 1'b0, "inv_l2");
        wait_out(1, 2, V_COL_IN, "inv_l2");
        release_out(1, "inv_l2");

        // Inverse and bypass on LANES=4
        start(2, V_COL_OUT, 1'b1, 1'b0, "inv_l4");
        wait_out(2, 1, V_COL_IN, "inv_l4");
        release_out(2, "inv_l4");

        start(2, V_MIXED, 1'b1, 1'b1, "byp_l4");
        wait_out(2, 1, V_MIXED, "byp_l4");
        release_out(2, "byp_l4");

        // Backpressure: DONE held for 10 cycles while a new input is offered
        start(1, V_COL_IN, 1'b0, 1'b0, "bp_l2");
        wait_out(1, 2, V_COL_OUT, "bp_l2");
        for (int c = 0; c < 10; c++) begin
            in_valid[1] = 1'b1;
            din[1]      = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv[1]      = c[0];
            tick();
            chk_vec("bp dout stable", dout[1], V_COL_OUT);
            chk_bit("bp out_valid held", out_valid[1], 1'b1);
            chk_bit("bp in_ready low", in_ready[1], 1'b0);
        end
        in_valid[1] = 1'b0;
        release_out(1, "bp_l2");
        chk_bit("bp busy after release", busy[1], 1'b0);

        // Mode isolation, LANES=1: inputs scrambled every BUSY cycle,
        // out_ready driven high while still computing.
        start(0, V_SHIFTED, 1'b0, 1'b0, "iso_l1");
        n = 0;
        while (!out_valid[0] && n < 20) begin
            inv[0]       = ~inv[0];
            bypass[0]    = ~bypass[0];
            din[0]       = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready[0] = 1'b1;
            tick();
            n++;
        end
        out_ready[0] = 1'b0;
        chk_int("iso_l1 latency", n, 4);
        chk_vec("iso_l1 dout", dout[0], V_MIXED);
        release_out(0, "iso_l1");
        inv[0]    = 1'b0;
        bypass[0] = 1'b0;

        // Reset during BUSY, LANES=1, cnt=2
        start(0, V_MIXED, 1'b1, 1'b0, "rst_l1");
        tick();
        tick();
        chk_bit("rst_l1 still busy", busy[0], 1'b1);
        rst[0] = 1'b1;
        #1;
        chk_bit("rst_l1 in_ready during rst", in_ready[0], 1'b0);
        tick();
        rst[0] = 1'b0;
        #1;
        chk_bit("rst_l1 out_valid", out_valid[0], 1'b0);
        chk_vec("rst_l1 dout", dout[0], 128'h0);
        chk_bit("rst_l1 busy", busy[0], 1'b0);
        chk_bit("rst_l1 in_ready", in_ready[0], 1'b1);
        held       = dout[0];
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid[0]) seen_valid++;
        end
        chk_int("rst_l1 discarded block", seen_valid, 0);
        start(0, V_MIXED, 1'b1, 1'b0, "after_rst_l1");
        wait_out(0, 4, V_SHIFTED, "after_rst_l1");
        release_out(0, "after_rst_l1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Parametrised, handshaked successor to the combinational InvMixColumns stage.
- Runs either forward MixColumns (FIPS-197 5.1.3) or InvMixColumns (5.3.3) on a 128-bit state, or passes it through unchanged (bypass).
- Processes LANES columns per cycle, so area can be traded against latency.
- Sits between the ShiftRows/SubBytes logic and AddRoundKey in an iterative encrypt/decrypt round datapath.

Parameters:
- LANES, 1, columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NCYC, 4/LANES, derived (localparam, not overridable): compute cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  [0:127]  input state. Column j = din[32j +: 32]; byte S0c is the MSB of the column.
- inv  input  1  1 = InvMixColumns, 0 = MixColumns; sampled with din
- bypass  input  1  1 = dout equals the captured din; sampled with din
- in_valid  input  1  din/inv/bypass valid
- in_ready  output  1  block can accept input
- dout  output  [0:127]  result, same column/byte ordering as din
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, col counter=0, dout=0, out_valid=0.
  - in_ready=0 while rst=1.
  - Reset mid-operation discards the block in flight; no out_valid is produced for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register din, inv and bypass, clear cnt, go to BUSY.
  - BUSY: each cycle transform columns cnt..cnt+LANES-1 of the captured state in place, then cnt += LANES.
    - When cnt+LANES == 4, go to DONE.
    - LANES=4 gives exactly one BUSY cycle.
  - DONE: out_valid=1 and dout=result.
    - dout and out_valid hold stable until out_ready=1.
    - On out_valid&&out_ready, go to IDLE next cycle.
- Latency: handshake at edge T, out_valid high after edge T+NCYC.
  - Minimum spacing between accepted inputs is NCYC+2 cycles.
  - No overlap: in_ready=0 in BUSY and DONE.
- Bypass: same latency and handshake as the other modes; the result equals the captured din.
- inv/bypass changing after capture has no effect on the block in flight.
- Column arithmetic is in GF(2^8) with reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
  - Forward matrix: rows {02 03 01 01} rotated.
  - Inverse matrix: rows {0e 0b 0d 09} rotated.
  - Both are implemented as shared xtime chains per lane.
  - Purely combinational within a cycle; no multipliers or ROMs.
- in_valid with in_ready=0 is ignored; the source must hold it.
- out_ready asserted outside DONE has no effect.
- busy = (state != IDLE).

Test Plan:
- Forward, LANES=4, inv=0, din=d4bf5d30e0b452aeb84111f11e2798e5.
  -> dout=046681e5e0cb199a48f8d37a2806264c, out_valid 1 cycle after the handshake.
- Inverse round-trip, LANES=1, inv=1, din=046681e5e0cb199a48f8d37a2806264c.
  -> dout=d4bf5d30e0b452aeb84111f11e2798e5, out_valid exactly 4 cycles after the handshake.
- Column vectors, LANES=2, inv=0, din=db135345_f20a225c_01010101_c6c6c6c6.
  -> dout=8e4da1bc_9fdc589d_01010101_c6c6c6c6 after 2 cycles.
  -> The same din with bypass=1 returns din unchanged after 2 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  -> dout and out_valid stay stable, in_ready=0 and a new in_valid is not accepted.
  -> out_ready=1 gives in_ready=1 on the following cycle.
- Mode isolation: toggle inv and bypass, and change din, every cycle during BUSY.
  -> Result matches the values captured at the handshake.
- Reset: assert rst for 1 cycle during BUSY (LANES=1, cnt=2).
  -> Next cycle out_valid=0, dout=0, busy=0, in_ready=1.
  -> A subsequent block completes with correct data.
